// File: rtl/ped_crossing_ctrl.sv
// rtl/ped_crossing_ctrl.sv - pedestrian crossing controller slaved to the vehicle lamps
// Optional PED_COUNTDOWN_EN adds the countdown output for the remaining WALK+CLEAR cycles.
module ped_crossing_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WALK_CYCLES     = 6,
  parameter int CLEAR_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic       car_red,
  input  logic       car_yellow,
  input  logic       car_green,
  output logic       walk,
  output logic       dont_walk,
  output logic       req_pending,
  output logic [1:0] ped_state
`ifdef PED_COUNTDOWN_EN
  ,
  output logic [7:0] countdown
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_WALK  = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  localparam logic [7:0] DEB_LAST   = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] WALK_LAST  = 8'(WALK_CYCLES - 1);
  localparam logic [7:0] CLEAR_LAST = 8'(CLEAR_CYCLES - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       deb_q, deb_d;
  logic [7:0] deb_cnt_q, deb_cnt_d;
  logic       pure_red_q, pure_red_d;
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       req_q, req_d;
  logic       walk_q, walk_d;
  logic       dont_walk_q, dont_walk_d;

  logic press;
  logic pure_red;
  logic red_entry;
  logic req_or_press;

  always_comb begin
    sync1_d   = button;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_cnt_d = 8'd0;
    press     = 1'b0;
    // Any cycle where the synchronized level agrees with deb_q restarts the count.
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = sync2_q;
        press = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 8'd1;
      end
    end
  end

  assign pure_red     = car_red & ~car_yellow & ~car_green;
  assign red_entry    = pure_red & ~pure_red_q;
  assign pure_red_d   = pure_red;
  assign req_or_press = req_q | press;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    walk_d      = 1'b0;
    dont_walk_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (press) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (red_entry) begin
          state_d = ST_WALK;
          cnt_d   = 8'd0;
        end
      end
      ST_WALK: begin
        if (!pure_red) begin
          state_d = req_or_press ? ST_WAIT : ST_IDLE;
          cnt_d   = 8'd0;
        end else if (cnt_q == WALK_LAST) begin
          state_d = ST_CLEAR;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_CLEAR: begin
        if (!pure_red || cnt_q == CLEAR_LAST) begin
          state_d = req_or_press ? ST_WAIT : ST_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    // WALK entry serves the pending request; a simultaneous press survives only if none was pending.
    if (state_q == ST_WAIT && state_d == ST_WALK) begin
      req_d = press & ~req_q;
    end else if (press) begin
      req_d = 1'b1;
    end

    case (state_d)
      ST_WALK: begin
        walk_d      = 1'b1;
        dont_walk_d = 1'b0;
      end
      ST_CLEAR: begin
        dont_walk_d = (state_q == ST_CLEAR) ? ~dont_walk_q : 1'b0;
      end
      default: begin
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      deb_q       <= 1'b0;
      deb_cnt_q   <= 8'd0;
      pure_red_q  <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      req_q       <= 1'b0;
      walk_q      <= 1'b0;
      dont_walk_q <= 1'b1;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_cnt_q   <= deb_cnt_d;
      pure_red_q  <= pure_red_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      walk_q      <= walk_d;
      dont_walk_q <= dont_walk_d;
    end
  end

  assign walk        = walk_q;
  assign dont_walk   = dont_walk_q;
  assign req_pending = req_q;
  assign ped_state   = state_q;

`ifdef PED_COUNTDOWN_EN
  localparam int         CD_SUM  = WALK_CYCLES + CLEAR_CYCLES;
  localparam logic [7:0] CD_LOAD = (CD_SUM > 255) ? 8'd255 : 8'(CD_SUM);

  logic [7:0] cd_q, cd_d;

  always_comb begin
    cd_d = 8'd0;
    if (state_d == ST_WALK && state_q != ST_WALK) begin
      cd_d = CD_LOAD;
    end else if (state_d == ST_WALK || state_d == ST_CLEAR) begin
      cd_d = (cd_q != 8'd0) ? cd_q - 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cd_q <= 8'd0;
    else     cd_q <= cd_d;
  end

  assign countdown = cd_q;
`endif

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb/tb_ped_crossing_ctrl.sv - scoreboard bench for ped_crossing_ctrl against a timestamp-based model
// Define PED_COUNTDOWN_EN to also check the countdown output.
module tb_ped_crossing_ctrl;

  localparam int D = 4;
  localparam int W = 6;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic       car_red;
  logic       car_yellow;
  logic       car_green;
  logic       walk;
  logic       dont_walk;
  logic       req_pending;
  logic [1:0] ped_state;
`ifdef PED_COUNTDOWN_EN
  logic [7:0] countdown;
`endif

  ped_crossing_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .WALK_CYCLES    (W),
    .CLEAR_CYCLES   (C)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button     (button),
    .car_red    (car_red),
    .car_yellow (car_yellow),
    .car_green  (car_green),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .req_pending(req_pending),
    .ped_state  (ped_state)
`ifdef PED_COUNTDOWN_EN
    ,
    .countdown  (countdown)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int walk;
    int dw;
    int req;
    int st;
    int cd;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   mon_cyc = 0;

  // Reference model: button samples by edge index, phases tracked by entry timestamps.
  bit samp[$];
  int m_k;
  bit m_deb;
  bit m_prev_pr;
  int m_phase;
  int m_start;
  int m_wstart;
  bit m_req;
  int btn_hold;
  bit btn_lvl;

  function automatic void chk(string name, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, mon_cyc, act, want);
    end
  endfunction

  function automatic void model_reset();
    samp.delete();
    samp.push_back(1'b0);
    m_k       = 0;
    m_deb     = 1'b0;
    m_prev_pr = 1'b1;
    m_phase   = 0;
    m_start   = 0;
    m_wstart  = 0;
    m_req     = 1'b0;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e.walk = 0; e.dw = 1; e.req = 0; e.st = 0; e.cd = 0;
    return e;
  endfunction

  function automatic void model_edge(bit b, bit r, bit y, bit g);
    bit   flip;
    bit   press;
    bit   pr;
    bit   entry;
    bit   rp;
    bit   v;
    int   idx;
    int   nxt;
    exp_t e;
    m_k++;
    samp.push_back(b);
    // The debouncer at edge k sees the button sampled two edges earlier; flip when the last D all disagree.
    flip = 1'b1;
    for (int j = 0; j < D; j++) begin
      idx = m_k - 2 - j;
      v   = (idx >= 1) ? samp[idx] : 1'b0;
      if (v == m_deb) flip = 1'b0;
    end
    press = 1'b0;
    if (flip) begin
      m_deb = ~m_deb;
      press = m_deb;
    end
    pr        = r && !y && !g;
    entry     = pr && !m_prev_pr;
    m_prev_pr = pr;
    rp        = m_req || press;
    nxt       = m_phase;
    case (m_phase)
      0: if (press) nxt = 1;
      1: if (entry) nxt = 2;
      2: begin
        if (!pr) nxt = rp ? 1 : 0;
        else if (m_k - m_start == W) nxt = 3;
      end
      default: begin
        if (!pr || m_k - m_start == C) nxt = rp ? 1 : 0;
      end
    endcase
    if (m_phase == 1 && nxt == 2) m_req = press && !m_req;
    else if (press) m_req = 1'b1;
    if (nxt != m_phase) begin
      m_start = m_k;
      if (nxt == 2) m_wstart = m_k;
    end
    m_phase = nxt;
    e.st   = nxt;
    e.walk = (nxt == 2) ? 1 : 0;
    e.dw   = (nxt < 2) ? 1 : (nxt == 2) ? 0 : ((m_k - m_start) % 2);
    e.req  = m_req ? 1 : 0;
    e.cd   = (nxt >= 2) ? (W + C - (m_k - m_wstart)) : 0;
    exp_q.push_back(e);
  endfunction

  task automatic step(input bit b, input bit r, input bit y, input bit g);
    @(negedge clk);
    rst        = 1'b0;
    button     = b;
    car_red    = r;
    car_yellow = y;
    car_green  = g;
    model_edge(b, r, y, g);
  endtask

  task automatic run(input int n, input bit b, input bit r, input bit y, input bit g);
    for (int i = 0; i < n; i++) step(b, r, y, g);
  endtask

  task automatic rnd_lamp(input int n, input bit r, input bit y, input bit g);
    bit [2:0] lamps;
    for (int i = 0; i < n; i++) begin
      if (btn_hold == 0) begin
        btn_lvl  = ~btn_lvl;
        btn_hold = $urandom_range(1, 12);
      end
      btn_hold--;
      lamps = {r, y, g};
      if ($urandom_range(0, 59) == 0) lamps = 3'($urandom_range(0, 7));
      step(btn_lvl, lamps[2], lamps[1], lamps[0]);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        mon_cyc++;
        chk("walk", walk, e.walk);
        chk("dont_walk", dont_walk, e.dw);
        chk("req_pending", req_pending, e.req);
        chk("ped_state", ped_state, e.st);
`ifdef PED_COUNTDOWN_EN
        chk("countdown", countdown, e.cd);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    button     = 1'b1;
    car_red    = 1'b1;
    car_yellow = 1'b0;
    car_green  = 1'b0;
    model_reset();
    btn_hold = 0;
    btn_lvl  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      exp_q.push_back(reset_exp());
    end

    // Press held across reset release with red already steady: no WALK without a red entry.
    run(5, 1'b1, 1'b1, 1'b0, 1'b0);
    run(10, 1'b0, 1'b1, 1'b0, 1'b0);
    run(5, 1'b0, 1'b0, 1'b0, 1'b1);
    run(14, 1'b0, 1'b1, 1'b0, 1'b0);

    // Bouncing button never settles; then a clean hold.
    for (int i = 0; i < 5; i++) begin
      run(3, 1'b1, 1'b1, 1'b0, 1'b0);
      run(1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    run(8, 1'b1, 1'b1, 1'b0, 1'b0);
    run(4, 1'b0, 1'b1, 1'b0, 1'b0);

    // Normal cycle.
    run(5, 1'b0, 1'b0, 1'b0, 1'b1);
    run(12, 1'b0, 1'b1, 1'b0, 1'b0);

    // Abort during WALK via yellow.
    run(8, 1'b1, 1'b0, 1'b0, 1'b1);
    run(3, 1'b0, 1'b0, 1'b0, 1'b1);
    run(3, 1'b0, 1'b1, 1'b0, 1'b0);
    run(1, 1'b0, 1'b1, 1'b1, 1'b0);
    run(4, 1'b0, 1'b1, 1'b0, 1'b0);

    // Repeat request pressed during WALK, served at the following red entry.
    run(8, 1'b1, 1'b0, 1'b0, 1'b1);
    run(3, 1'b0, 1'b0, 1'b0, 1'b1);
    run(1, 1'b0, 1'b1, 1'b0, 1'b0);
    run(7, 1'b1, 1'b1, 1'b0, 1'b0);
    run(8, 1'b0, 1'b1, 1'b0, 1'b0);
    run(5, 1'b0, 1'b0, 1'b0, 1'b1);
    run(14, 1'b0, 1'b1, 1'b0, 1'b0);

    // Late request during steady red, served at the next green->red transition.
    run(7, 1'b1, 1'b1, 1'b0, 1'b0);
    run(10, 1'b0, 1'b1, 1'b0, 1'b0);
    run(5, 1'b0, 1'b0, 1'b0, 1'b1);
    run(14, 1'b0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic-light cycles with a randomly held button and occasional illegal lamps.
    for (int cyc = 0; cyc < 80; cyc++) begin
      rnd_lamp($urandom_range(3, 10), 1'b0, 1'b0, 1'b1);
      rnd_lamp($urandom_range(1, 3), 1'b0, 1'b1, 1'b0);
      rnd_lamp($urandom_range(4, 20), 1'b1, 1'b0, 1'b0);
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) chk("scoreboard_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
